if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word used as a pipeline bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 stall  in  1  hazard hold: freeze PC and IF/ID register.
REQ-006 flush  in  1  external kill: load bubble into IF/ID.
REQ-007 imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle.
REQ-008 id_s_npc  in  2  next-PC select of the ID-stage instruction: 00 seq, 01 jump, 10 jr, 11 branch.
REQ-009 id_br_eq  in  1  ID-stage rs==rt compare result for beq.
REQ-010 id_jr_target  in  32  forwarded rs value for jr.
REQ-011 imem_addr  out  32  current PC.
REQ-012 if_id_instr  out  32  registered instruction for ID.
REQ-013 if_id_pc  out  32  registered PC of if_id_instr.
REQ-014 if_id_pc4  out  32  registered if_id_pc+4.
REQ-015 if_id_valid  out  1  IF/ID holds a real instruction.

Function
REQ-016 imem_addr SHALL equal the PC register; no combinational path from any input to imem_addr.
REQ-017 Targets are computed from IF/ID contents: jump = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}; jr = id_jr_target; branch = if_id_pc4 + (sign-extended if_id_instr[15:0] << 2), 32-bit wrap-around, carry discarded.
REQ-018 redirect SHALL be asserted when if_id_valid=1 and (id_s_npc=01, or id_s_npc=10, or id_s_npc=11 with id_br_eq=1); id_s_npc=00, or 11 with id_br_eq=0, is sequential.
REQ-019 No branch delay slot: a redirect SHALL kill the instruction fetched in the same cycle.
REQ-020 Priority per edge: reset > stall > redirect > flush > sequential.
REQ-021 stall=1: PC and all IF/ID outputs SHALL hold; a redirect or flush raised in the same cycle SHALL be ignored and re-evaluated after stall clears.
REQ-022 redirect (no stall): PC <= selected target; IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc and pc4 = 0).
REQ-023 flush without redirect (no stall): PC <= PC+4; IF/ID <= bubble.
REQ-024 sequential: PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0); IF/ID <= {imem_rdata, PC, PC+4, valid=1}.
REQ-025 A bubble SHALL never cause a redirect, regardless of id_s_npc or id_br_eq.
REQ-026 Unaligned targets (jr with low bits set) SHALL be loaded unmodified; alignment checking is out of scope.
REQ-027 Fetch-to-ID latency is one cycle; redirect penalty is exactly one bubble.

Reset
REQ-028 reset=1 at an edge: PC <= RESET_PC, if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_pc4 <= 0, if_id_valid <= 0, overriding stall, flush and redirect.
REQ-029 Reset asserted mid-redirect or mid-stall SHALL leave no residual state; the first cycle after release fetches RESET_PC.

Verification
REQ-030 Reset then 3 free cycles, imem returns 0x11,0x22,0x33 -> imem_addr 0x3000,0x3004,0x3008; if_id_instr 0x11 with if_id_pc 0x3000, valid=1.
REQ-031 if_id_instr=0x08000C10 (j), if_id_pc=0x3004, id_s_npc=01 -> next imem_addr 0x0000_3040, if_id_valid=0 for one cycle.
REQ-032 beq imm 0xFFFF at if_id_pc 0x3010, id_s_npc=11: id_br_eq=1 -> PC 0x3010; id_br_eq=0 -> PC continues +4, no bubble.
REQ-033 stall=1 for 2 cycles with pending jr (id_jr_target 0x3100) -> PC and IF/ID unchanged; after release PC=0x3100 and one bubble.
REQ-034 flush=1 and stall=0, no redirect -> PC+4, IF/ID bubble; flush+redirect together -> redirect target taken.
REQ-035 reset asserted with stall=1 and pending jump -> PC=0x3000, if_id_valid=0 next cycle.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC from ID-stage redirect
// information and registers the fetched instruction into the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  id_s_npc,
    input  logic        id_br_eq,
    input  logic [31:0] id_jr_target,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_JUMP   = 2'b01;
    localparam logic [1:0] NPC_JR     = 2'b10;
    localparam logic [1:0] NPC_BRANCH = 2'b11;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] branch_offset;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] redirect_target;
    logic            redirect;

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + XLEN'(4);

    // Targets derive only from IF/ID contents so a bubble carries no stale target
    assign jump_target   = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    assign branch_offset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    assign branch_target = if_id_pc4 + branch_offset;

    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc_plus4;
        if (if_id_valid) begin
            case (id_s_npc)
                NPC_JUMP: begin
                    redirect        = 1'b1;
                    redirect_target = jump_target;
                end
                NPC_JR: begin
                    redirect        = 1'b1;
                    redirect_target = id_jr_target;
                end
                NPC_BRANCH: begin
                    redirect        = id_br_eq;
                    redirect_target = branch_target;
                end
                NPC_SEQ: begin
                    redirect        = 1'b0;
                    redirect_target = pc_plus4;
                end
                default: begin
                    redirect        = 1'b0;
                    redirect_target = pc_plus4;
                end
            endcase
        end
    end

    // Priority: reset > stall > redirect > flush > sequential fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            pc_q        <= pc_q;
            if_id_instr <= if_id_instr;
            if_id_pc    <= if_id_pc;
            if_id_pc4   <= if_id_pc4;
            if_id_valid <= if_id_valid;
        end else if (redirect) begin
            pc_q        <= redirect_target;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            pc_q        <= pc_plus4;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            pc_q        <= pc_plus4;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc_q;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural next-PC / IF-ID model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] imem_rdata;
    logic [1:0]  id_s_npc;
    logic        id_br_eq;
    logic [31:0] id_jr_target;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .imem_rdata   (imem_rdata),
        .id_s_npc     (id_s_npc),
        .id_br_eq     (id_br_eq),
        .id_jr_target (id_jr_target),
        .imem_addr    (imem_addr),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_idpc  = '0;
    logic [31:0] m_pc4   = '0;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_update(input logic r, input logic s, input logic f, input logic [1:0] npc,
                                input logic beq, input logic [31:0] jr, input logic [31:0] rd);
        logic        taken;
        logic [31:0] tgt;
        int          off;
        taken = 1'b0;
        tgt   = '0;
        off   = int'($signed(m_instr[15:0])) * 4;
        if (m_valid) begin
            if (npc == 2'd1) begin
                taken = 1'b1;
                tgt   = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            end else if (npc == 2'd2) begin
                taken = 1'b1;
                tgt   = jr;
            end else if (npc == 2'd3 && beq) begin
                taken = 1'b1;
                tgt   = m_pc4 + 32'(off);
            end
        end
        if (r) begin
            m_pc = RST_PC; m_instr = NOP; m_idpc = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (taken) begin
            m_pc = tgt; m_instr = NOP; m_idpc = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 32'd4; m_instr = NOP; m_idpc = '0; m_pc4 = '0; m_valid = 1'b0;
        end else begin
            m_instr = rd; m_idpc = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [1:0] npc,
                        input logic beq, input logic [31:0] jr, input logic [31:0] rd);
        reset = r; stall = s; flush = f; id_s_npc = npc; id_br_eq = beq;
        id_jr_target = jr; imem_rdata = rd;
        model_update(r, s, f, npc, beq, jr, rd);
        @(posedge clk);
        #1;
        check("imem_addr",   imem_addr,   m_pc);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc",    if_id_pc,    m_idpc);
        check("if_id_pc4",   if_id_pc4,   m_pc4);
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; id_s_npc = 2'b00; id_br_eq = 1'b0;
        id_jr_target = '0; imem_rdata = '0;
        #2;

        // Reset state
        step(1, 0, 0, 2'd0, 0, 0, 0);
        check("rst_addr",  imem_addr, 32'h3000);
        check("rst_valid", 32'(if_id_valid), 32'd0);

        // Three free fetch cycles
        step(0, 0, 0, 2'd0, 0, 0, 32'h11);
        check("seq_addr1",  imem_addr,   32'h3004);
        check("seq_instr1", if_id_instr, 32'h11);
        check("seq_pc1",    if_id_pc,    32'h3000);
        check("seq_valid1", 32'(if_id_valid), 32'd1);
        step(0, 0, 0, 2'd0, 0, 0, 32'h22);
        check("seq_addr2", imem_addr, 32'h3008);
        step(0, 0, 0, 2'd0, 0, 0, 32'h33);
        check("seq_addr3", imem_addr, 32'h300C);

        // Jump from 0x3004 to 0x3040, then a bubble that must not redirect
        step(1, 0, 0, 2'd0, 0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0, 32'h0);
        step(0, 0, 0, 2'd0, 0, 0, 32'h0800_0C10);
        check("j_idpc", if_id_pc, 32'h3004);
        step(0, 0, 0, 2'd1, 0, 0, 32'hDEAD_BEEF);
        check("j_addr",  imem_addr, 32'h3040);
        check("j_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 2'd1, 1, 32'h9999_0000, 32'h44);
        check("bubble_noredir_addr", imem_addr, 32'h3044);
        check("bubble_noredir_pc",   if_id_pc,  32'h3040);

        // beq imm 0xFFFF at 0x3010: taken loops to itself, not-taken falls through
        step(1, 0, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'd0, 0, 0, 32'h0);
        step(0, 0, 0, 2'd0, 0, 0, 32'h1000_FFFF);
        check("beq_idpc", if_id_pc, 32'h3010);
        step(0, 0, 0, 2'd3, 1, 0, 32'h66);
        check("beq_t_addr",  imem_addr, 32'h3010);
        check("beq_t_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 2'd0, 0, 0, 32'h1000_FFFF);
        step(0, 0, 0, 2'd3, 0, 0, 32'h55);
        check("beq_nt_addr",  imem_addr, 32'h3018);
        check("beq_nt_valid", 32'(if_id_valid), 32'd1);

        // Stall two cycles with pending jr, then redirect
        step(0, 1, 0, 2'd2, 0, 32'h3100, 32'hAA);
        step(0, 1, 1, 2'd2, 0, 32'h3100, 32'hBB);
        check("stall_addr", imem_addr, 32'h3018);
        check("stall_pc",   if_id_pc,  32'h3014);
        step(0, 0, 0, 2'd2, 0, 32'h3100, 32'hCC);
        check("jr_addr",  imem_addr, 32'h3100);
        check("jr_valid", 32'(if_id_valid), 32'd0);

        // Flush alone, then flush together with redirect
        step(0, 0, 1, 2'd0, 0, 0, 32'h12);
        check("flush_addr",  imem_addr,   32'h3104);
        check("flush_instr", if_id_instr, NOP);
        step(0, 0, 0, 2'd0, 0, 0, 32'h77);
        step(0, 0, 1, 2'd2, 0, 32'h3200, 32'h88);
        check("flush_redir_addr", imem_addr, 32'h3200);

        // Reset overrides stall and pending jump
        step(0, 0, 0, 2'd0, 0, 0, 32'h0800_0C10);
        step(1, 1, 0, 2'd1, 0, 0, 32'h99);
        check("rst_ovr_addr",  imem_addr, 32'h3000);
        check("rst_ovr_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 2'd0, 0, 0, 32'h5);
        check("rst_rel_pc", if_id_pc, 32'h3000);

        // Wrap-around and unaligned jr target
        step(0, 0, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h6);
        step(0, 0, 0, 2'd0, 0, 0, 32'h7);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4",  if_id_pc4, 32'h0);
        step(0, 0, 0, 2'd2, 0, 32'h0000_3001, 32'h8);
        check("unaligned_addr", imem_addr, 32'h3001);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic        r, s, f, b;
            logic [1:0]  n;
            logic [31:0] jr, rd;
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            f  = ($urandom_range(0, 99) < 15);
            b  = 1'($urandom_range(0, 1));
            n  = 2'($urandom_range(0, 3));
            jr = $urandom;
            rd = $urandom;
            step(r, s, f, n, b, jr, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
